load_store_unit: RTL and testbench

Parametrised, sequential load/store unit that replaces the purely combinational memory-address stage of the core pipeline. It does the following:

- Accepts one memory instruction at a time from execute, computes the effective address and checks alignment.
- Generates byte enables and lane-aligned store data, and runs a request/grant/response handshake with the data memory.
- Returns sign- or zero-extended load data, tagged with the destination register, to writeback.

---
 rtl/load_store_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Sequential load/store unit between execute and writeback. It takes one
// memory instruction at a time, forms the effective address, checks
// alignment, and runs a req/gnt/rvalid handshake with the data memory.
// Load results are extended and returned with the destination register.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o request handshake from execute
//   mem_op_i                {store, unsigned, size[1:0]}
//   base_i, imm_i, wdata_i  rs1, offset, rs2
//   rd_i, kill_i            load destination, pipeline flush
//   rsp_*                   one-cycle response to writeback
//   misalign_o, fault_o     exceptions, qualified by rsp_valid_o
//   fault_addr_o            effective address of the operation
//   dmem_*                  data memory request/grant/response
//   busy_o                  high whenever the unit is not idle
module load_store_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        mem_op_i,
  input  logic [XLEN-1:0]   base_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              kill_i,
  output logic              rsp_valid_o,
  output logic              rsp_we_o,
  output logic [RD_W-1:0]   rsp_rd_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              misalign_o,
  output logic              fault_o,
  output logic [XLEN-1:0]   fault_addr_o,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i,
  output logic              busy_o
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, RESP} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] ea_q;
  logic [BW-1:0]   be_q;
  logic [XLEN-1:0] wdata_q;
  logic            store_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [RD_W-1:0] rd_q;
  logic            mis_q;
  logic            fault_q;
  logic [XLEN-1:0] rdata_q;

  // Request-side decode, evaluated on the incoming operands in IDLE.
  logic [XLEN-1:0] ea;
  logic [1:0]      size_in;
  logic [OW-1:0]   off_in;
  logic [2:0]      amask;
  logic            misalign_in;
  logic [BW-1:0]   be_base;
  logic [BW-1:0]   be_in;
  logic [XLEN-1:0] wdata_rep;

  assign ea      = base_i + imm_i;
  assign size_in = mem_op_i[1:0];
  assign off_in  = ea[OW-1:0];
  assign be_in   = be_base << off_in;

  // Size-dependent alignment mask, byte-enable pattern and store lane
  // replication. A double access on a 32-bit datapath is reported as
  // misaligned so it never reaches memory.
  always_comb begin
    amask     = 3'b111;
    be_base   = '1;
    wdata_rep = wdata_i;
    case (size_in)
      2'd0: begin
        amask     = 3'b000;
        be_base   = BW'(8'h01);
        wdata_rep = {BW{wdata_i[7:0]}};
      end
      2'd1: begin
        amask     = 3'b001;
        be_base   = BW'(8'h03);
        wdata_rep = {(XLEN/16){wdata_i[15:0]}};
      end
      2'd2: begin
        amask     = 3'b011;
        be_base   = BW'(8'h0F);
        wdata_rep = {(XLEN/32){wdata_i[31:0]}};
      end
      default: begin
        amask     = 3'b111;
        be_base   = '1;
        wdata_rep = wdata_i;
      end
    endcase
    misalign_in = ((ea[2:0] & amask) != 3'b000) ||
                  ((size_in == 2'b11) && (XLEN == 32));
  end

  // Load-side extraction: shift the addressed lane down, keep 2^size bytes,
  // then fill the upper bits with the sign bit for signed loads.
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign_bit;
  logic [XLEN-1:0] load_ext;

  assign shifted = dmem_rdata_i >> {ea_q[OW-1:0], 3'b000};

  always_comb begin
    keep_mask = '1;
    sign_bit  = 1'b0;
    case (size_q)
      2'd0: begin
        keep_mask = XLEN'(64'hFF);
        sign_bit  = shifted[7];
      end
      2'd1: begin
        keep_mask = XLEN'(64'hFFFF);
        sign_bit  = shifted[15];
      end
      2'd2: begin
        keep_mask = XLEN'(64'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = 1'b0;
      end
    endcase
    load_ext = (shifted & keep_mask) |
               ({XLEN{sign_bit & ~uns_q}} & ~keep_mask);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A kill that coincides with a grant still leaves a
  // response outstanding, so the unit must drain it before going idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !kill_i) state_d = misalign_in ? RESP : REQ;
      end
      REQ: begin
        if (dmem_gnt_i)  state_d = kill_i ? DRAIN : WAIT;
        else if (kill_i) state_d = IDLE;
      end
      WAIT: begin
        if (dmem_rvalid_i) state_d = kill_i ? IDLE : RESP;
        else if (kill_i)   state_d = DRAIN;
      end
      DRAIN: begin
        if (dmem_rvalid_i) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation and response registers. Request fields are captured on
  // acceptance and hold steady through the grant stall; the memory result
  // is captured only on the response that completes the operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ea_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i && !kill_i) begin
        ea_q    <= ea;
        be_q    <= be_in;
        wdata_q <= wdata_rep;
        store_q <= mem_op_i[3];
        uns_q   <= mem_op_i[2];
        size_q  <= size_in;
        rd_q    <= rd_i;
        mis_q   <= misalign_in;
        fault_q <= 1'b0;
        rdata_q <= '0;
      end
      if (state_q == WAIT && dmem_rvalid_i) begin
        fault_q <= dmem_err_i;
        rdata_q <= load_ext;
      end
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = (state_q == REQ) && store_q;
  assign dmem_addr_o  = {ea_q[XLEN-1:OW], {OW{1'b0}}};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_we_o     = (state_q == RESP) && !store_q && !mis_q && !fault_q;
  assign misalign_o   = (state_q == RESP) && mis_q;
  assign fault_o      = (state_q == RESP) && fault_q;
  assign rsp_data_o   = rsp_we_o ? rdata_q : '0;
  assign rsp_rd_o     = rd_q;
  assign fault_addr_o = ea_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Drives a 32-bit and a 64-bit load_store_unit from shared stimulus; only
// the instance selected by use64 sees req_valid, and its outputs are
// muxed onto common 64-bit observation wires. A vector table covers the
// single-operation cases, hand sequences cover stalls, kills and reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        use64;
  logic        req_valid;
  logic [3:0]  op;
  logic [63:0] base, imm, wdata, rdata;
  logic [4:0]  rd;
  logic        kill, gnt, rvalid, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 32-bit instance outputs
  logic        a_ready, a_busy, a_req, a_we, a_rv, a_rwe, a_mis, a_flt;
  logic [4:0]  a_rd;
  logic [31:0] a_data, a_faddr, a_addr, a_wdata;
  logic [3:0]  a_be;
  // 64-bit instance outputs
  logic        b_ready, b_busy, b_req, b_we, b_rv, b_rwe, b_mis, b_flt;
  logic [4:0]  b_rd;
  logic [63:0] b_data, b_faddr, b_addr, b_wdata;
  logic [7:0]  b_be;

  load_store_unit #(.XLEN(32), .RD_W(5)) dut32 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & ~use64), .req_ready_o(a_ready),
    .mem_op_i(op), .base_i(base[31:0]), .imm_i(imm[31:0]),
    .wdata_i(wdata[31:0]), .rd_i(rd), .kill_i(kill),
    .rsp_valid_o(a_rv), .rsp_we_o(a_rwe), .rsp_rd_o(a_rd),
    .rsp_data_o(a_data), .misalign_o(a_mis), .fault_o(a_flt),
    .fault_addr_o(a_faddr),
    .dmem_req_o(a_req), .dmem_gnt_i(gnt), .dmem_we_o(a_we),
    .dmem_addr_o(a_addr), .dmem_be_o(a_be), .dmem_wdata_o(a_wdata),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0]), .dmem_err_i(err),
    .busy_o(a_busy)
  );

  load_store_unit #(.XLEN(64), .RD_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid & use64), .req_ready_o(b_ready),
    .mem_op_i(op), .base_i(base), .imm_i(imm),
    .wdata_i(wdata), .rd_i(rd), .kill_i(kill),
    .rsp_valid_o(b_rv), .rsp_we_o(b_rwe), .rsp_rd_o(b_rd),
    .rsp_data_o(b_data), .misalign_o(b_mis), .fault_o(b_flt),
    .fault_addr_o(b_faddr),
    .dmem_req_o(b_req), .dmem_gnt_i(gnt), .dmem_we_o(b_we),
    .dmem_addr_o(b_addr), .dmem_be_o(b_be), .dmem_wdata_o(b_wdata),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .dmem_err_i(err),
    .busy_o(b_busy)
  );

  // Observation wires for whichever instance is under test
  logic        o_ready, o_busy, o_req, o_we, o_rv, o_rwe, o_mis, o_flt;
  logic [4:0]  o_rd;
  logic [63:0] o_data, o_faddr, o_addr, o_wdata;
  logic [7:0]  o_be;

  assign o_ready = use64 ? b_ready : a_ready;
  assign o_busy  = use64 ? b_busy  : a_busy;
  assign o_req   = use64 ? b_req   : a_req;
  assign o_we    = use64 ? b_we    : a_we;
  assign o_rv    = use64 ? b_rv    : a_rv;
  assign o_rwe   = use64 ? b_rwe   : a_rwe;
  assign o_mis   = use64 ? b_mis   : a_mis;
  assign o_flt   = use64 ? b_flt   : a_flt;
  assign o_rd    = use64 ? b_rd    : a_rd;
  assign o_data  = use64 ? b_data  : {32'h0, a_data};
  assign o_faddr = use64 ? b_faddr : {32'h0, a_faddr};
  assign o_addr  = use64 ? b_addr  : {32'h0, a_addr};
  assign o_wdata = use64 ? b_wdata : {32'h0, a_wdata};
  assign o_be    = use64 ? b_be    : {4'h0, a_be};

  typedef struct {
    logic        wide;
    logic [3:0]  op;
    logic [63:0] base;
    logic [63:0] imm;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] ea;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] ewdata;
    logic [63:0] data;
    logic        rwe;
    logic        mis;
    logic        fault;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setRequest(input logic w, input logic [3:0] o,
                            input logic [63:0] b, input logic [63:0] i,
                            input logic [63:0] wd, input logic [4:0] r);
    use64 = w; op = o; base = b; imm = i; wdata = wd; rd = r;
  endtask

  // One complete operation: accept, then either an immediate misaligned
  // response or grant next cycle and rvalid the cycle after (min latency).
  task automatic applyStimulus(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    setRequest(v.wide, v.op, v.base, v.imm, v.wdata, v.rd);
    checkOutput({p, ".ready"}, o_ready, 1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (v.mis) begin
      checkOutput({p, ".req"},   o_req, 0);
      checkOutput({p, ".rv"},    o_rv, 1);
      checkOutput({p, ".mis"},   o_mis, 1);
      checkOutput({p, ".flt"},   o_flt, 0);
      checkOutput({p, ".rwe"},   o_rwe, 0);
      checkOutput({p, ".faddr"}, o_faddr, v.ea);
    end else begin
      checkOutput({p, ".req"},   o_req, 1);
      checkOutput({p, ".ready"}, o_ready, 0);
      checkOutput({p, ".we"},    o_we, {63'h0, v.op[3]});
      checkOutput({p, ".addr"},  o_addr, v.addr);
      checkOutput({p, ".be"},    {56'h0, o_be}, {56'h0, v.be});
      if (v.op[3]) checkOutput({p, ".wdata"}, o_wdata, v.ewdata);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      checkOutput({p, ".req_w"}, o_req, 0);
      checkOutput({p, ".rv_w"},  o_rv, 0);
      rvalid = 1'b1; rdata = v.rdata; err = v.err;
      tick();
      rvalid = 1'b0; err = 1'b0;
      checkOutput({p, ".rv"},    o_rv, 1);
      checkOutput({p, ".data"},  o_data, v.data);
      checkOutput({p, ".rwe"},   o_rwe, {63'h0, v.rwe});
      checkOutput({p, ".flt"},   o_flt, {63'h0, v.fault});
      checkOutput({p, ".mis"},   o_mis, 0);
      if (v.fault) checkOutput({p, ".faddr"}, o_faddr, v.ea);
    end
    checkOutput({p, ".rd"}, {59'h0, o_rd}, {59'h0, v.rd});
    tick();
    checkOutput({p, ".rv_end"},    o_rv, 0);
    checkOutput({p, ".ready_end"}, o_ready, 1);
  endtask

  initial begin
    //        wide op       base                  imm                   wdata                 rd     rdata                 err  ea                    addr                  be     ewdata                data                  rwe mis flt
    vecs[0]  = '{0, 4'b0000, 64'h1000,             64'h3,                64'h0,                5'd1,  64'h80FF1234,         0, 64'h1003,             64'h1000,             8'h08, 64'h0,                64'hFFFFFF80,         1, 0, 0};
    vecs[1]  = '{0, 4'b0100, 64'h1000,             64'h3,                64'h0,                5'd2,  64'h80FF1234,         0, 64'h1003,             64'h1000,             8'h08, 64'h0,                64'h80,               1, 0, 0};
    vecs[2]  = '{0, 4'b1001, 64'h2000,             64'h2,                64'hAAAABEEF,         5'd3,  64'h0,                0, 64'h2002,             64'h2000,             8'h0C, 64'hBEEFBEEF,         64'h0,                0, 0, 0};
    vecs[3]  = '{0, 4'b0010, 64'h3000,             64'h1,                64'h0,                5'd4,  64'h0,                0, 64'h3001,             64'h0,                8'h00, 64'h0,                64'h0,                0, 1, 0};
    vecs[4]  = '{0, 4'b0011, 64'h4000,             64'h0,                64'h0,                5'd5,  64'h0,                0, 64'h4000,             64'h0,                8'h00, 64'h0,                64'h0,                0, 1, 0};
    vecs[5]  = '{0, 4'b0001, 64'h1000,             64'h2,                64'h0,                5'd6,  64'h80017FFF,         0, 64'h1002,             64'h1000,             8'h0C, 64'h0,                64'hFFFF8001,         1, 0, 0};
    vecs[6]  = '{0, 4'b0010, 64'hFFFFFFFC,         64'h8,                64'h0,                5'd7,  64'hDEADBEEF,         0, 64'h4,                64'h4,                8'h0F, 64'h0,                64'hDEADBEEF,         1, 0, 0};
    vecs[7]  = '{0, 4'b1000, 64'h5000,             64'h1,                64'h12345678,         5'd8,  64'h0,                0, 64'h5001,             64'h5000,             8'h02, 64'h78787878,         64'h0,                0, 0, 0};
    vecs[8]  = '{0, 4'b0101, 64'h6000,             64'h0,                64'h0,                5'd9,  64'h1234F00D,         0, 64'h6000,             64'h6000,             8'h03, 64'h0,                64'hF00D,             1, 0, 0};
    vecs[9]  = '{0, 4'b0010, 64'h7000,             64'h0,                64'h0,                5'd10, 64'hDEADBEEF,         1, 64'h7000,             64'h7000,             8'h0F, 64'h0,                64'h0,                0, 0, 1};
    vecs[10] = '{0, 4'b1010, 64'h8000,             64'h0,                64'hCAFEBABE,         5'd11, 64'h0,                0, 64'h8000,             64'h8000,             8'h0F, 64'hCAFEBABE,         64'h0,                0, 0, 0};
    vecs[11] = '{0, 4'b0000, 64'h1010,             64'hFFFFFFFFFFFFFFF0, 64'h0,                5'd12, 64'h1234567F,         0, 64'h1000,             64'h1000,             8'h01, 64'h0,                64'h7F,               1, 0, 0};
    vecs[12] = '{0, 4'b0001, 64'h2000,             64'h1,                64'h0,                5'd13, 64'h0,                0, 64'h2001,             64'h0,                8'h00, 64'h0,                64'h0,                0, 1, 0};
    vecs[13] = '{1, 4'b0011, 64'h100,              64'h8,                64'h0,                5'd14, 64'h8877665544332211, 0, 64'h108,              64'h108,              8'hFF, 64'h0,                64'h8877665544332211, 1, 0, 0};
    vecs[14] = '{1, 4'b0010, 64'h100,              64'hC,                64'h0,                5'd15, 64'h8000000100000000, 0, 64'h10C,              64'h108,              8'hF0, 64'h0,                64'hFFFFFFFF80000001, 1, 0, 0};
    vecs[15] = '{1, 4'b0110, 64'h100,              64'hC,                64'h0,                5'd16, 64'h8000000100000000, 0, 64'h10C,              64'h108,              8'hF0, 64'h0,                64'h80000001,         1, 0, 0};
    vecs[16] = '{1, 4'b0011, 64'h100,              64'h4,                64'h0,                5'd17, 64'h0,                0, 64'h104,              64'h0,                8'h00, 64'h0,                64'h0,                0, 1, 0};
    vecs[17] = '{1, 4'b1000, 64'h100,              64'h3,                64'hAB,               5'd18, 64'h0,                0, 64'h103,              64'h100,              8'h08, 64'hABABABABABABABAB, 64'h0,                0, 0, 0};

    rst = 1'b1; use64 = 1'b0; req_valid = 1'b0; kill = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    setRequest(0, 4'b0000, 64'h0, 64'h0, 64'h0, 5'd0);
    tick();
    tick();

    // Reset values of both instances
    for (int w = 0; w < 2; w++) begin
      use64 = (w == 1);
      #1;
      checkOutput("rst.ready", o_ready, 1);
      checkOutput("rst.busy",  o_busy, 0);
      checkOutput("rst.req",   o_req, 0);
      checkOutput("rst.we",    o_we, 0);
      checkOutput("rst.rv",    o_rv, 0);
      checkOutput("rst.rwe",   o_rwe, 0);
      checkOutput("rst.mis",   o_mis, 0);
      checkOutput("rst.flt",   o_flt, 0);
      checkOutput("rst.addr",  o_addr, 0);
      checkOutput("rst.be",    {56'h0, o_be}, 0);
      checkOutput("rst.wdata", o_wdata, 0);
      checkOutput("rst.data",  o_data, 0);
      checkOutput("rst.rd",    {59'h0, o_rd}, 0);
      checkOutput("rst.faddr", o_faddr, 0);
    end
    rst = 1'b0;
    use64 = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) applyStimulus(vecs[i], i);

    // Grant stall of 5 cycles on a store that then returns an error
    $display("[TB] grant stall");
    setRequest(0, 4'b1010, 64'h9000, 64'h4, 64'h11223344, 5'd3);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("stall%0d.req", c),   o_req, 1);
      checkOutput($sformatf("stall%0d.addr", c),  o_addr, 64'h9004);
      checkOutput($sformatf("stall%0d.be", c),    {56'h0, o_be}, 64'hF);
      checkOutput($sformatf("stall%0d.wdata", c), o_wdata, 64'h11223344);
      if (c < 5) tick();
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1; err = 1'b1;
    tick();
    rvalid = 1'b0; err = 1'b0;
    checkOutput("stall.rv",    o_rv, 1);
    checkOutput("stall.flt",   o_flt, 1);
    checkOutput("stall.rwe",   o_rwe, 0);
    checkOutput("stall.faddr", o_faddr, 64'h9004);
    tick();

    // Kill in WAIT, response arrives three cycles later and is dropped
    $display("[TB] kill in wait");
    setRequest(0, 4'b0010, 64'hA000, 64'h0, 64'h0, 5'd4);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("drain%0d.busy", c),  o_busy, 1);
      checkOutput($sformatf("drain%0d.ready", c), o_ready, 0);
      checkOutput($sformatf("drain%0d.rv", c),    o_rv, 0);
      if (c == 2) begin rvalid = 1'b1; rdata = 64'h55; end
      tick();
    end
    rvalid = 1'b0;
    checkOutput("drain.ready", o_ready, 1);
    checkOutput("drain.rv",    o_rv, 0);
    tick();
    checkOutput("drain.rv2",   o_rv, 0);

    // Kill in REQ without a grant
    $display("[TB] kill in req");
    setRequest(0, 4'b0010, 64'hB000, 64'h0, 64'h0, 5'd5);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checkOutput("kreq.ready", o_ready, 1);
    checkOutput("kreq.req",   o_req, 0);
    checkOutput("kreq.busy",  o_busy, 0);
    tick();
    checkOutput("kreq.rv",    o_rv, 0);

    // Request with kill in IDLE is ignored
    req_valid = 1'b1; kill = 1'b1;
    tick();
    req_valid = 1'b0; kill = 1'b0;
    checkOutput("kidle.ready", o_ready, 1);
    checkOutput("kidle.req",   o_req, 0);
    checkOutput("kidle.rv",    o_rv, 0);

    // Wrapped address, then reset in WAIT and a late rvalid
    $display("[TB] reset in wait");
    setRequest(0, 4'b0010, 64'hFFFFFFFC, 64'h8, 64'h0, 5'd9);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("rw.addr", o_addr, 64'h4);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    checkOutput("rw.busy", o_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rw.ready", o_ready, 1);
    checkOutput("rw.busy0", o_busy, 0);
    checkOutput("rw.req",   o_req, 0);
    checkOutput("rw.rv",    o_rv, 0);
    checkOutput("rw.addr0", o_addr, 0);
    checkOutput("rw.be0",   {56'h0, o_be}, 0);
    checkOutput("rw.data0", o_data, 0);
    checkOutput("rw.rd0",   {59'h0, o_rd}, 0);
    checkOutput("rw.fa0",   o_faddr, 0);
    rvalid = 1'b1; rdata = 64'h1234;
    tick();
    rvalid = 1'b0;
    checkOutput("rw.late_rv",   o_rv, 0);
    checkOutput("rw.late_busy", o_busy, 0);
    tick();
    checkOutput("rw.late_rv2",  o_rv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
